// File: rtl/stack_lifo_if.sv
// Handshake and status bundle for the stack_lifo LIFO: request/data from the
// master side, registered top-of-stack and status back from the stack.
interface stack_lifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             clear;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, clear, data_in,
        input  data_out, count, full, empty, almost_full, overflow, underflow
    );

    modport slave (
        input  push, pop, clear, data_in,
        output data_out, count, full, empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/stack_lifo.sv
// Parametrised LIFO with a registered top-of-stack, occupancy count,
// almost-full threshold and sticky overflow/underflow flags.
module stack_lifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input logic        clk,
    input logic        rst_n,
    stack_lifo_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [CW-1:0]    count_p0, count_d;
    logic [WIDTH-1:0] top_p0, top_d;
    logic             ovf_p0, ovf_d;
    logic             udf_p0, udf_d;
    logic             wr_en;
    logic [IW-1:0]    wr_idx;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == DEPTH_C) ? c : c + 1'b1;
    endfunction

    function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    // Operation decode: clear > replace > push > pop > hold
    always_comb begin
        count_d = count_p0;
        top_d   = top_p0;
        ovf_d   = ovf_p0;
        udf_d   = udf_p0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        if (bus.clear) begin
            count_d = '0;
            top_d   = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else if (bus.push && bus.pop && count_p0 != '0) begin
            wr_en  = 1'b1;
            wr_idx = IW'(count_p0 - 1'b1);
            top_d  = bus.data_in;
        end else if (bus.push) begin
            if (count_p0 == DEPTH_C) begin
                ovf_d = 1'b1;
            end else begin
                wr_en   = 1'b1;
                wr_idx  = IW'(count_p0);
                count_d = sat_inc(count_p0);
                top_d   = bus.data_in;
            end
        end else if (bus.pop) begin
            if (count_p0 == '0) begin
                udf_d = 1'b1;
            end else begin
                count_d = sat_dec(count_p0);
                // the entry below the current top becomes the new top
                top_d   = (count_p0 > CW'(1)) ? mem[IW'(count_p0 - CW'(2))] : '0;
            end
        end
    end

    // Stage p0: storage array carries no reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_p0 <= '0;
            top_p0   <= '0;
            ovf_p0   <= 1'b0;
            udf_p0   <= 1'b0;
        end else begin
            count_p0 <= count_d;
            top_p0   <= top_d;
            ovf_p0   <= ovf_d;
            udf_p0   <= udf_d;
        end
    end

    assign bus.data_out    = top_p0;
    assign bus.count       = count_p0;
    assign bus.full        = (count_p0 == DEPTH_C);
    assign bus.empty       = (count_p0 == '0);
    assign bus.almost_full = (count_p0 >= AF_C);
    assign bus.overflow    = ovf_p0;
    assign bus.underflow   = udf_p0;
endmodule

// File: tb/tb_stack_lifo.sv
// Bench for stack_lifo: hand-written vector table, random ops against a
// reference model, and an asynchronous reset taken mid-burst.
module tb_stack_lifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stack_lifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
    stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit       pu;
        bit       po;
        bit       cl;
        logic [7:0] din;
        int       dout;
        int       count;
        bit       ovf;
        bit       udf;
    } vec_t;

    typedef struct {
        int dout;
        int count;
        bit ovf;
        bit udf;
    } exp_t;

    vec_t vt[$];
    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    int m_mem [DEPTH];
    int m_cnt;
    bit m_ovf, m_udf;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk({tag, " data_out"},    int'(bus.data_out),    e.dout);
        chk({tag, " count"},       int'(bus.count),       e.count);
        chk({tag, " full"},        int'(bus.full),        int'(e.count == DEPTH));
        chk({tag, " empty"},       int'(bus.empty),       int'(e.count == 0));
        chk({tag, " almost_full"}, int'(bus.almost_full), int'(e.count >= AF));
        chk({tag, " overflow"},    int'(bus.overflow),    int'(e.ovf));
        chk({tag, " underflow"},   int'(bus.underflow),   int'(e.udf));
    endtask

    task automatic reset_values(input string tag);
        chk({tag, " data_out"},    int'(bus.data_out),    0);
        chk({tag, " count"},       int'(bus.count),       0);
        chk({tag, " full"},        int'(bus.full),        0);
        chk({tag, " empty"},       int'(bus.empty),       1);
        chk({tag, " almost_full"}, int'(bus.almost_full), 0);
        chk({tag, " overflow"},    int'(bus.overflow),    0);
        chk({tag, " underflow"},   int'(bus.underflow),   0);
    endtask

    task automatic step(input bit pu, input bit po, input bit cl,
                        input logic [7:0] d, input exp_t e, input string tag);
        @(negedge clk);
        bus.push    = pu;
        bus.pop     = po;
        bus.clear   = cl;
        bus.data_in = d;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic model_step(input bit pu, input bit po, input bit cl,
                              input logic [7:0] d, output exp_t e);
        if (cl) begin
            m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
        end else if (pu && po && m_cnt > 0) begin
            m_mem[m_cnt-1] = int'(d);
        end else if (pu) begin
            if (m_cnt == DEPTH) m_ovf = 1'b1;
            else begin
                m_mem[m_cnt] = int'(d);
                m_cnt++;
            end
        end else if (po) begin
            if (m_cnt == 0) m_udf = 1'b1;
            else m_cnt--;
        end
        e.dout  = (m_cnt == 0) ? 0 : m_mem[m_cnt-1];
        e.count = m_cnt;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
    endtask

    task automatic v(input bit pu, input bit po, input bit cl, input logic [7:0] d,
                     input int dout, input int cnt, input bit ovf, input bit udf);
        vt.push_back('{pu, po, cl, d, dout, cnt, ovf, udf});
    endtask

    initial begin
        exp_t e;
        bit   pu, po, cl;
        logic [7:0] d;

        // push/pop walk
        v(1,0,0,8'h11, 8'h11,1,0,0);
        v(1,0,0,8'h22, 8'h22,2,0,0);
        v(1,0,0,8'h33, 8'h33,3,0,0);
        v(1,0,0,8'h44, 8'h44,4,0,0);
        v(0,1,0,8'h00, 8'h33,3,0,0);
        v(0,1,0,8'h00, 8'h22,2,0,0);
        v(0,1,0,8'h00, 8'h11,1,0,0);
        v(0,1,0,8'h00, 8'h00,0,0,0);
        // overflow on full, sticky through a pop
        v(1,0,0,8'h11, 8'h11,1,0,0);
        v(1,0,0,8'h22, 8'h22,2,0,0);
        v(1,0,0,8'h33, 8'h33,3,0,0);
        v(1,0,0,8'h44, 8'h44,4,0,0);
        v(1,0,0,8'h55, 8'h44,4,1,0);
        v(0,1,0,8'h00, 8'h33,3,1,0);
        v(1,0,0,8'h44, 8'h44,4,1,0);
        v(0,0,0,8'hEE, 8'h44,4,1,0);
        v(0,0,1,8'h00, 8'h00,0,0,0);
        // replace when full
        v(1,0,0,8'h11, 8'h11,1,0,0);
        v(1,0,0,8'h22, 8'h22,2,0,0);
        v(1,0,0,8'h33, 8'h33,3,0,0);
        v(1,0,0,8'h44, 8'h44,4,0,0);
        v(1,1,0,8'h99, 8'h99,4,0,0);
        v(0,1,0,8'h00, 8'h33,3,0,0);
        v(0,1,0,8'h00, 8'h22,2,0,0);
        v(0,1,0,8'h00, 8'h11,1,0,0);
        v(0,1,0,8'h00, 8'h00,0,0,0);
        // underflow, then push+pop on empty is a plain push
        v(0,1,0,8'h00, 8'h00,0,0,1);
        v(1,1,0,8'h66, 8'h66,1,0,1);
        v(1,1,0,8'h67, 8'h67,1,0,1);
        v(1,0,0,8'h70, 8'h70,2,0,1);
        // clear beats a simultaneous push
        v(1,0,1,8'h77, 8'h00,0,0,0);
        v(0,0,0,8'h00, 8'h00,0,0,0);

        bus.push = 1'b0; bus.pop = 1'b0; bus.clear = 1'b0; bus.data_in = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            e.dout = vt[i].dout; e.count = vt[i].count; e.ovf = vt[i].ovf; e.udf = vt[i].udf;
            step(vt[i].pu, vt[i].po, vt[i].cl, vt[i].din, e, $sformatf("vec%0d", i));
        end

        // random traffic against the reference model
        m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
        for (int i = 0; i < 300; i++) begin
            pu = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            cl = ($urandom_range(0, 24) == 0);
            d  = 8'($urandom_range(0, 255));
            model_step(pu, po, cl, d, e);
            step(pu, po, cl, d, e, $sformatf("rnd%0d", i));
        end

        // fill past full, then drop reset between edges
        model_step(0, 0, 1, 8'h00, e);
        step(0, 0, 1, 8'h00, e, "pre_clear");
        for (int i = 0; i < 5; i++) begin
            model_step(1, 0, 0, 8'(8'hA0 + i), e);
            step(1, 0, 0, 8'(8'hA0 + i), e, $sformatf("burst%0d", i));
        end
        @(negedge clk);
        bus.push = 1'b1; bus.pop = 1'b0; bus.data_in = 8'hBB;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_values("async_rst");
        @(posedge clk);
        #1;
        reset_values("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        bus.push = 1'b0;
        m_cnt = 0; m_ovf = 1'b0; m_udf = 1'b0;
        model_step(0, 0, 0, 8'h00, e);
        step(0, 0, 0, 8'h00, e, "post_rst_idle");
        model_step(1, 0, 0, 8'h5A, e);
        step(1, 0, 0, 8'h5A, e, "post_rst_push");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
